// File: rtl/stream_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter_pkg
// Brief    : Shared helpers for the round-robin stream arbiter
// Revision : 1.0 - initial release
// ============================================================================
package stream_rr_arbiter_pkg;

    // Source-index width; a single requester still gets a 1-bit index so
    // that no zero-width vectors appear anywhere.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Priority pointer value after reset: requester 0 is served first.
    localparam int RST_PTR = 0;

endpackage
`default_nettype wire

// File: rtl/stream_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter_rr_pick
// Brief    : Combinational round-robin picker; first set req at or after ptr
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter_rr_pick
    import stream_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // Scan ptr, ptr+1, ... modulo N and keep the first requester found.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!gnt_valid && req[j]) begin
                gnt_idx   = IDX_W'(j);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : stream_rr_arbiter
// Brief    : N-to-1 packet-aware round-robin arbiter with registered output
// Revision : 1.0 - initial release
// ============================================================================
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_width(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_src
);

    logic [IDX_W-1:0] w_ptr;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_cand;
    logic             w_gnt_valid;
    logic             w_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;

    logic             r_lock;
    logic [IDX_W-1:0] r_lock_src;

    stream_rr_arbiter_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req       (in_valid),
        .ptr       (w_ptr),
        .gnt_idx   (w_pick_idx),
        .gnt_valid (w_pick_valid)
    );

    // A locked packet owns the grant even while its requester is idle.
    assign w_load      = ~out_valid | out_ready;
    assign w_cand      = r_lock ? r_lock_src : w_pick_idx;
    assign w_gnt_valid = r_lock ? in_valid[r_lock_src] : w_pick_valid;
    assign w_accept    = w_load & w_gnt_valid & ~rst;
    assign w_sel_data  = in_data[int'(w_cand)*WIDTH +: WIDTH];
    assign w_sel_last  = in_last[w_cand];

    // One-hot ready towards the granted requester only.
    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_cand] = 1'b1;
        end
    end

    generate
        if (N == 1) begin : g_ptr_const
            assign w_ptr = IDX_W'(RST_PTR);
        end else begin : g_ptr_reg
            logic [IDX_W-1:0] r_ptr;
            logic [IDX_W-1:0] w_next_ptr;

            assign w_next_ptr = (int'(w_cand) == N-1) ? '0 : w_cand + IDX_W'(1);
            assign w_ptr      = r_ptr;

            // Requester after the winner gets top priority next time.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= IDX_W'(RST_PTR);
                end else if (w_accept) begin
                    r_ptr <= w_next_ptr;
                end
            end
        end
    endgenerate

    // Packet lock: held from the first beat until the last beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock     <= 1'b0;
            r_lock_src <= '0;
        end else if (w_accept) begin
            r_lock     <= ~w_sel_last;
            r_lock_src <= w_cand;
        end
    end

    // Output pipeline register: load on accept, empty when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
            out_data  <= w_sel_data;
            out_last  <= w_sel_last;
            out_src   <= w_cand;
        end else if (w_load) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Brief    : Self-checking bench for stream_rr_arbiter (N=4, WIDTH=8)
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_rr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic [31:0] data;
        logic [3:0]  exp_rdy;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] src;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [31:0]  in_data = '0;
    logic [3:0]   in_last = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         out_last;
    logic [1:0]   out_src;

    int     checks = 0;
    int     errors = 0;
    logic   m_ov   = 1'b0;
    beat_t  sb[$];
    vec_t   tbl[$];

    stream_rr_arbiter #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every transferred beat must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected actual=%h/%b/%0d expected=none", out_data, out_last, out_src);
            end else begin
                beat_t e;
                e = sb.pop_front();
                checks++;
                if ({out_data, out_last, out_src} !== e) begin
                    errors++;
                    $display("FAIL beat actual=%h/%b/%0d expected=%h/%b/%0d",
                             out_data, out_last, out_src, e.data, e.last, e.src);
                end
            end
        end
    end

    // Drive one cycle, check ready and out_valid, and advance the model.
    task automatic apply(input vec_t v);
        logic load;
        in_valid  = v.valid;
        in_last   = v.last;
        out_ready = v.ready;
        in_data   = v.data;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(v.exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        load = !m_ov || v.ready;
        if (v.exp_rdy != 4'b0000) begin
            for (int g = 0; g < N; g++) begin
                if (v.exp_rdy[g]) begin
                    beat_t b;
                    b.data = v.data[g*8 +: 8];
                    b.last = v.last[g];
                    b.src  = 2'(g);
                    sb.push_back(b);
                end
            end
            m_ov = 1'b1;
        end else if (load) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] va, input logic [3:0] la, input logic rd,
                                input logic [31:0] d, input logic [3:0] er);
        vec_t v;
        v.valid = va; v.last = la; v.ready = rd; v.data = d; v.exp_rdy = er;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with all requesters valid.
        rst      = 1'b1;
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin on single-beat packets: 10,11,12,13,10.
        for (int i = 0; i < 5; i++)
            add(4'b1111, 4'b1111, 1'b1, 32'h13121110, 4'(1 << (i % 4)));
        run_tbl();

        // Backpressure with req2 (ptr=1): 3C held for three stalled cycles.
        add(4'b0100, 4'b1111, 1'b1, 32'h003C0000, 4'b0100);
        run_tbl();
        for (int i = 0; i < 3; i++) begin
            add(4'b0100, 4'b1111, 1'b0, 32'h003D0000, 4'b0000);
            run_tbl();
            check("bp_hold_data", 32'(out_data), 32'h3C);
            check("bp_hold_valid", 32'(out_valid), 32'h1);
        end
        add(4'b0100, 4'b1111, 1'b1, 32'h003D0000, 4'b0100);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        run_tbl();

        // Packet lock: req1 sends A1,A2,A3 while req0/req3 wait; then req3.
        add(4'b0001, 4'b1111, 1'b1, 32'h00000020, 4'b0001);
        add(4'b1011, 4'b1101, 1'b1, 32'h3300A130, 4'b0010);
        add(4'b1011, 4'b1101, 1'b1, 32'h3300A230, 4'b0010);
        add(4'b1011, 4'b1111, 1'b1, 32'h3300A330, 4'b0010);
        add(4'b1001, 4'b1111, 1'b1, 32'h33000030, 4'b1000);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        run_tbl();

        // Lock stall: req1 idles mid-packet, req3 must not be served.
        add(4'b1010, 4'b1101, 1'b1, 32'h3300B100, 4'b0010);
        add(4'b1000, 4'b1111, 1'b1, 32'h33000000, 4'b0000);
        add(4'b1000, 4'b1111, 1'b1, 32'h33000000, 4'b0000);
        add(4'b1010, 4'b1111, 1'b1, 32'h3300B200, 4'b0010);
        add(4'b1000, 4'b1111, 1'b1, 32'h33000000, 4'b1000);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        run_tbl();

        // Mid-packet reset: C2 sits in the output register and is dropped.
        add(4'b0010, 4'b1101, 1'b1, 32'h0000C100, 4'b0010);
        add(4'b0010, 4'b1101, 1'b1, 32'h0000C200, 4'b0010);
        run_tbl();
        rst = 1'b1;
        sb.delete();
        m_ov = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        check("midrst_out_data", 32'(out_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        add(4'b0011, 4'b1111, 1'b1, 32'h0000C340, 4'b0001);
        add(4'b0010, 4'b1111, 1'b1, 32'h0000C300, 4'b0010);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        add(4'b0000, 4'b1111, 1'b1, 32'h00000000, 4'b0000);
        run_tbl();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
